csr_unit: RTL and testbench

CSR_UNIT -- requirements
Module: csr_unit

---
 rtl/csr_unit.sv | 205 ++++++++++++++++++++
 tb/tb_csr_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_unit.sv
// rtl/csr_unit.sv - machine-mode CSR file with interrupt entry and MRET redirect
// Optional CSR_VECTORED_EN enables vectored mtvec mode (mtvec[1:0] = 1).
module csr_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        csr_reg_wr,
  input  logic        csr_reg_rd,
  input  logic [31:0] inst,
  input  logic [31:0] csr_wdata,
  input  logic [31:0] pc,
  input  logic        is_mret,
  input  logic        timer_irq,
  input  logic        ext_irq,
  output logic [31:0] csr_rdata,
  output logic        epc_taken,
  output logic [31:0] epc
);

  typedef enum logic [1:0] {RUN, TRAP, RET} state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  localparam logic [31:0] CAUSE_EXT   = 32'h8000_000B;
  localparam logic [31:0] CAUSE_TIMER = 32'h8000_0007;

  state_t state, state_nxt;

  logic        mstatus_mie, mstatus_mpie;
  logic        mie_mtie, mie_meie;
  logic        mip_mtip, mip_meip;
  logic [29:0] mtvec_base;
  logic        mtvec_mode;
  logic [29:0] mepc_q;
  logic [31:0] mcause_q;

  logic [11:0] csr_addr;
  logic [4:0]  rs1_field;
  logic [2:0]  funct3;
  logic [31:0] cur_val;
  logic [31:0] src_val;
  logic [31:0] wr_val;
  logic        op_we;
  logic        irq_take;
  logic        mret_take;
  logic        csr_we;
  logic [31:0] trap_target;
  logic        unused_ok;

  assign csr_addr  = inst[31:20];
  assign rs1_field = inst[19:15];
  assign funct3    = inst[14:12];
  assign unused_ok = ^{inst[11:0], pc[1:0], mcause_q[31:30]};

  always_comb begin
    cur_val = 32'd0;
    case (csr_addr)
      ADDR_MSTATUS: cur_val = {24'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
      ADDR_MIE:     cur_val = {20'd0, mie_meie, 3'd0, mie_mtie, 7'd0};
      ADDR_MTVEC:   cur_val = {mtvec_base, 1'b0, mtvec_mode};
      ADDR_MEPC:    cur_val = {mepc_q, 2'b00};
      ADDR_MCAUSE:  cur_val = mcause_q;
      ADDR_MIP:     cur_val = {20'd0, mip_meip, 3'd0, mip_mtip, 7'd0};
      default:      cur_val = 32'd0;
    endcase
  end

  // Read data is the value before any write this cycle takes effect.
  assign csr_rdata = csr_reg_rd ? cur_val : 32'd0;

  always_comb begin
    src_val = funct3[2] ? {27'd0, rs1_field} : csr_wdata;
    wr_val  = cur_val;
    op_we   = 1'b0;
    case (funct3[1:0])
      2'b01: begin
        wr_val = src_val;
        op_we  = 1'b1;
      end
      2'b10: begin
        wr_val = cur_val | src_val;
        op_we  = (rs1_field != 5'd0);
      end
      2'b11: begin
        wr_val = cur_val & ~src_val;
        op_we  = (rs1_field != 5'd0);
      end
      default: begin
        wr_val = cur_val;
        op_we  = 1'b0;
      end
    endcase
  end

`ifdef CSR_VECTORED_EN
  always_comb begin
    if (mtvec_mode)
      trap_target = {mtvec_base, 2'b00} + {mcause_q[29:0], 2'b00};
    else
      trap_target = {mtvec_base, 2'b00};
  end
`else
  assign trap_target = {mtvec_base, 2'b00};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= RUN;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    epc_taken = 1'b0;
    epc       = 32'd0;
    irq_take  = 1'b0;
    mret_take = 1'b0;
    csr_we    = 1'b0;
    case (state)
      RUN: begin
        irq_take  = mstatus_mie & ((mie_mtie & mip_mtip) | (mie_meie & mip_meip));
        mret_take = is_mret & ~irq_take;
        csr_we    = csr_reg_wr & op_we & ~irq_take;
        if (irq_take)
          state_nxt = TRAP;
        else if (mret_take)
          state_nxt = RET;
      end
      TRAP: begin
        epc_taken = 1'b1;
        epc       = trap_target;
        state_nxt = RUN;
      end
      RET: begin
        epc_taken = 1'b1;
        epc       = {mepc_q, 2'b00};
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_meie     <= 1'b0;
      mip_mtip     <= 1'b0;
      mip_meip     <= 1'b0;
      mtvec_base   <= 30'd0;
      mepc_q       <= 30'd0;
      mcause_q     <= 32'd0;
    end else begin
      mip_mtip <= timer_irq;
      mip_meip <= ext_irq;
      if (irq_take) begin
        mepc_q       <= pc[31:2];
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
        mcause_q     <= (mie_meie & mip_meip) ? CAUSE_EXT : CAUSE_TIMER;
      end else begin
        if (csr_we) begin
          case (csr_addr)
            ADDR_MSTATUS: begin
              mstatus_mie  <= wr_val[3];
              mstatus_mpie <= wr_val[7];
            end
            ADDR_MIE: begin
              mie_mtie <= wr_val[7];
              mie_meie <= wr_val[11];
            end
            ADDR_MTVEC:  mtvec_base <= wr_val[31:2];
            ADDR_MEPC:   mepc_q     <= wr_val[31:2];
            ADDR_MCAUSE: mcause_q   <= wr_val;
            default: ;
          endcase
        end
        // MRET's mstatus update overrides a same-cycle mstatus write.
        if (mret_take) begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
        end
      end
    end
  end

`ifdef CSR_VECTORED_EN
  // Only mode 0/1 are legal; any other written mode falls back to direct.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mtvec_mode <= 1'b0;
    else if (!irq_take && csr_we && csr_addr == ADDR_MTVEC)
      mtvec_mode <= (wr_val[1:0] == 2'b01);
  end
`else
  assign mtvec_mode = 1'b0;
`endif

endmodule

// File: tb/tb_csr_unit.sv
// tb/tb_csr_unit.sv - self-checking bench for csr_unit against a behavioural CSR model
// Expectations for vectored mtvec follow CSR_VECTORED_EN when it is defined.
module tb_csr_unit;

  logic        clk;
  logic        rst;
  logic        csr_reg_wr;
  logic        csr_reg_rd;
  logic [31:0] inst;
  logic [31:0] csr_wdata;
  logic [31:0] pc;
  logic        is_mret;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] csr_rdata;
  logic        epc_taken;
  logic [31:0] epc;

  int checks = 0;
  int errors = 0;

  csr_unit dut (
    .clk        (clk),
    .rst        (rst),
    .csr_reg_wr (csr_reg_wr),
    .csr_reg_rd (csr_reg_rd),
    .inst       (inst),
    .csr_wdata  (csr_wdata),
    .pc         (pc),
    .is_mret    (is_mret),
    .timer_irq  (timer_irq),
    .ext_irq    (ext_irq),
    .csr_rdata  (csr_rdata),
    .epc_taken  (epc_taken),
    .epc        (epc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural model: plain CSR values plus a pending-redirect kind (0 none, 1 trap, 2 mret).
  logic [31:0] m_mstatus = 0;
  logic [31:0] m_mie     = 0;
  logic [31:0] m_mtvec   = 0;
  logic [31:0] m_mepc    = 0;
  logic [31:0] m_mcause  = 0;
  logic [31:0] m_mip     = 0;
  int          m_redir   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h344: return m_mip;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_target();
    logic [31:0] base;
    base = m_mtvec & 32'hFFFF_FFFC;
`ifdef CSR_VECTORED_EN
    if (m_mtvec[1:0] == 2'b01)
      return base + (m_mcause & 32'h7FFF_FFFF) * 4;
`endif
    return base;
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [31:0] src, old, nv;
    logic        we;
    if (rst) begin
      m_mstatus = 0; m_mie = 0; m_mtvec = 0; m_mepc = 0;
      m_mcause = 0; m_mip = 0; m_redir = 0;
    end else begin
      if (m_redir != 0) begin
        m_redir = 0;
      end else if (m_mstatus[3] && (m_mie & m_mip) != 0) begin
        m_mepc    = pc & 32'hFFFF_FFFC;
        m_mstatus = m_mstatus[3] ? 32'h80 : 32'h0;
        m_mcause  = (m_mie[11] && m_mip[11]) ? 32'h8000_000B : 32'h8000_0007;
        m_redir   = 1;
      end else begin
        if (csr_reg_wr) begin
          src = inst[14] ? {27'd0, inst[19:15]} : csr_wdata;
          old = m_read(inst[31:20]);
          we  = 1'b0;
          nv  = old;
          if (inst[13:12] == 2'b01) begin nv = src; we = 1'b1; end
          else if (inst[13:12] == 2'b10 && inst[19:15] != 0) begin nv = old | src; we = 1'b1; end
          else if (inst[13:12] == 2'b11 && inst[19:15] != 0) begin nv = old & ~src; we = 1'b1; end
          if (we) begin
            case (inst[31:20])
              12'h300: m_mstatus = nv & 32'h88;
              12'h304: m_mie     = nv & 32'h880;
`ifdef CSR_VECTORED_EN
              12'h305: m_mtvec   = (nv & 32'hFFFF_FFFC) | ((nv[1:0] == 2'b01) ? 32'd1 : 32'd0);
`else
              12'h305: m_mtvec   = nv & 32'hFFFF_FFFC;
`endif
              12'h341: m_mepc    = nv & 32'hFFFF_FFFC;
              12'h342: m_mcause  = nv;
              default: ;
            endcase
          end
        end
        if (is_mret) begin
          m_mstatus = 32'h80 | (m_mstatus[7] ? 32'h8 : 32'h0);
          m_redir   = 2;
        end
      end
      m_mip = (timer_irq ? 32'h80 : 32'h0) | (ext_irq ? 32'h800 : 32'h0);
    end
  end

  always @(negedge clk) begin
    chk("rdata", csr_rdata, csr_reg_rd ? m_read(inst[31:20]) : 32'd0);
    chk("epc_taken", {31'd0, epc_taken}, (m_redir != 0) ? 32'd1 : 32'd0);
    chk("epc", epc, (m_redir == 1) ? m_target() : (m_redir == 2) ? m_mepc : 32'd0);
  end

  function automatic logic [31:0] mk(input logic [11:0] a, input logic [4:0] r, input logic [2:0] f3);
    return {a, r, f3, 5'd1, 7'b1110011};
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic op(input logic [2:0] f3, input logic [11:0] a, input logic [4:0] r, input logic [31:0] d);
    inst = mk(a, r, f3);
    csr_wdata = d;
    csr_reg_wr = 1'b1;
    csr_reg_rd = 1'b1;
    cyc(1);
    csr_reg_wr = 1'b0;
    csr_reg_rd = 1'b0;
  endtask

  task automatic rd_exp(input logic [11:0] a, input logic [31:0] e, input string nm);
    inst = mk(a, 5'd0, 3'b010);
    csr_reg_wr = 1'b0;
    csr_reg_rd = 1'b1;
    #1;
    chk(nm, csr_rdata, e);
  endtask

  initial begin
    rst = 1'b1; csr_reg_wr = 0; csr_reg_rd = 0; inst = 0; csr_wdata = 0;
    pc = 0; is_mret = 0; timer_irq = 0; ext_irq = 0;
    cyc(2);
    chk("rst_epc_taken", {31'd0, epc_taken}, 32'd0);
    chk("rst_epc", epc, 32'd0);
    rd_exp(12'h300, 32'h0, "rst_mstatus");
    rst = 1'b0;
    cyc(1);

    op(3'b001, 12'h305, 5'd1, 32'h100);
    rd_exp(12'h305, 32'h100, "mtvec_rw");
    cyc(1);
    op(3'b011, 12'h305, 5'd0, 32'hFFFF_FFFF);
    rd_exp(12'h305, 32'h100, "mtvec_rc_x0");
    cyc(1);

    op(3'b001, 12'h304, 5'd1, 32'h800);
    op(3'b110, 12'h300, 5'd8, 32'h0);
    rd_exp(12'h300, 32'h8, "mstatus_rsi");
    cyc(1);
    pc = 32'h40; ext_irq = 1'b1;
    csr_reg_rd = 1'b0;
    cyc(2);
    chk("ext_epc_taken", {31'd0, epc_taken}, 32'd1);
    chk("ext_epc", epc, 32'h100);
    ext_irq = 1'b0;
    cyc(1);
    rd_exp(12'h341, 32'h40, "ext_mepc");
    rd_exp(12'h342, 32'h8000_000B, "ext_mcause");
    cyc(1);
    rd_exp(12'h300, 32'h80, "ext_mstatus");
    csr_reg_rd = 1'b0;

    is_mret = 1'b1;
    cyc(1);
    is_mret = 1'b0;
    chk("mret_epc_taken", {31'd0, epc_taken}, 32'd1);
    chk("mret_epc", epc, 32'h40);
    rd_exp(12'h300, 32'h88, "mret_mstatus");
    cyc(1);

    op(3'b010, 12'h304, 5'd2, 32'h80);
    pc = 32'h80; timer_irq = 1'b1; ext_irq = 1'b1;
    cyc(2);
    timer_irq = 1'b0; ext_irq = 1'b0;
    chk("both_epc_taken", {31'd0, epc_taken}, 32'd1);
    cyc(1);
    rd_exp(12'h342, 32'h8000_000B, "both_mcause");
    is_mret = 1'b1;
    cyc(1);
    is_mret = 1'b0;
    cyc(1);

    timer_irq = 1'b1;
    cyc(1);
    pc = 32'hC0;
    op(3'b001, 12'h341, 5'd3, 32'h1234);
    timer_irq = 1'b0;
    rd_exp(12'h341, 32'hC0, "coinc_mepc");
    chk("coinc_epc_taken", {31'd0, epc_taken}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort_epc_taken", {31'd0, epc_taken}, 32'd0);
    chk("abort_epc", epc, 32'd0);
    cyc(1);
    rst = 1'b0;
    cyc(1);

    pc = 32'h200;
    op(3'b001, 12'h305, 5'd1, 32'h101);
`ifdef CSR_VECTORED_EN
    rd_exp(12'h305, 32'h101, "vec_mtvec");
`else
    rd_exp(12'h305, 32'h100, "vec_mtvec");
`endif
    cyc(1);
    op(3'b001, 12'h304, 5'd1, 32'h80);
    op(3'b110, 12'h300, 5'd8, 32'h0);
    timer_irq = 1'b1;
    cyc(2);
`ifdef CSR_VECTORED_EN
    chk("vec_epc", epc, 32'h11C);
`else
    chk("vec_epc", epc, 32'h100);
`endif
    cyc(1);
    rd_exp(12'h344, 32'h80, "mip_timer");
    timer_irq = 1'b0;
    cyc(1);

    op(3'b001, 12'h123, 5'd1, 32'hFFFF);
    rd_exp(12'h123, 32'h0, "unimpl_read");
    cyc(1);
    op(3'b001, 12'h344, 5'd1, 32'hFFFF_FFFF);
    rd_exp(12'h344, 32'h0, "mip_ro");
    cyc(1);
    op(3'b001, 12'h341, 5'd1, 32'h43);
    rd_exp(12'h341, 32'h40, "mepc_low");
    cyc(1);
    op(3'b101, 12'h300, 5'd8, 32'h0);
    rd_exp(12'h300, 32'h8, "mstatus_rwi");
    cyc(1);
    op(3'b111, 12'h300, 5'd8, 32'h0);
    rd_exp(12'h300, 32'h0, "mstatus_rci");
    csr_reg_rd = 1'b0;
    #1;
    chk("rdata_idle", csr_rdata, 32'h0);
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
